// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates a single-port unified memory between the instruction fetch
//   stage and the MEM (load/store) stage.  One access is in flight at a time;
//   each access holds m_* constant for MEM_LAT cycles, then the requester
//   receives a one-cycle ready pulse.  Between accesses there is always one
//   IDLE (turnaround) cycle.  When both sides are pending in IDLE, a
//   round-robin bit (last_d) picks the side not served most recently.
//
// Parameters
//   MEM_LAT   memory access latency in cycles (1..15)
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   if_req, if_addr               fetch request / address (held until if_ready)
//   if_rdata, if_ready            fetched word / one-cycle completion pulse
//   d_read, d_write               load / store request (held until d_ready)
//   d_addr, d_wdata, d_size       data address, store data, size (00 w,01 h,10 b)
//   d_rdata, d_ready              load data / one-cycle completion pulse
//   stall                         pipeline freeze request (combinational)
//   m_en, m_we, m_addr, m_wdata,
//   m_size, m_rdata               unified memory port
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        stall,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_size,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    INST = 2'b10
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic        last_d;
  logic        d_req;
  logic        d_pend;
  logic        i_pend;
  logic        grant_d;
  logic        grant_i;

  // A requester whose ready pulse is showing this cycle has just been served
  // and is not pending again until the following cycle.
  assign d_req  = d_read | d_write;
  assign d_pend = d_req & ~d_ready;
  assign i_pend = if_req & ~if_ready;

  assign stall = (d_req & ~d_ready) | (if_req & ~if_ready);

  // Grant decision in IDLE: data wins a tie only when it was not served last.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (d_pend && (!i_pend || !last_d)) begin
        grant_d = 1'b1;
      end else if (i_pend) begin
        grant_i = 1'b1;
      end else begin
        grant_d = 1'b0;
        grant_i = 1'b0;
      end
    end else begin
      grant_d = 1'b0;
      grant_i = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          next_state = DATA;
        end else if (grant_i) begin
          next_state = INST;
        end else begin
          next_state = IDLE;
        end
      end
      DATA, INST: begin
        if (cnt == 4'd0) begin
          next_state = IDLE;
        end else begin
          next_state = state;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Memory port, latency counter and round-robin bit.  Reset clears m_en and
  // m_we asynchronously, which aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
      m_size  <= 2'b00;
      cnt     <= 4'd0;
      last_d  <= 1'b0;
    end else if (grant_d) begin
      m_en    <= 1'b1;
      m_we    <= d_write;            // read+write together counts as a write
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      m_size  <= d_size;
      cnt     <= CNT_LOAD;
      last_d  <= 1'b1;
    end else if (grant_i) begin
      m_en    <= 1'b1;
      m_we    <= 1'b0;
      m_addr  <= if_addr;
      m_size  <= 2'b00;
      cnt     <= CNT_LOAD;
      last_d  <= 1'b0;
    end else if ((state == DATA || state == INST) && cnt != 4'd0) begin
      cnt     <= cnt - 4'd1;
    end else begin
      // Completion cycle or IDLE: port disabled, address/data/size held.
      m_en    <= 1'b0;
      m_we    <= 1'b0;
    end
  end

  // Completion: capture read data and raise the one-cycle ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (cnt == 4'd0 && state == DATA) begin
        d_ready <= 1'b1;
        if (!m_we) begin
          d_rdata <= m_rdata;        // stores leave the last load data intact
        end else begin
          d_rdata <= d_rdata;
        end
      end else if (cnt == 4'd0 && state == INST) begin
        if_ready <= 1'b1;
        if_rdata <= m_rdata;
      end else begin
        if_rdata <= if_rdata;
        d_rdata  <= d_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter.  Stimulus pushes the expected read data
//   and completion cycle of each transaction into a per-requester queue; a
//   monitor pops and compares on every ready pulse.  A logger records every
//   memory access (address, we, wdata, size, length) for grant-order checks.
//   A second instance with MEM_LAT=1 covers the minimum latency.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic        d_ready, stall;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_size;

  logic        if_req2;
  logic [31:0] if_addr2, if_rdata2, m_addr2, m_wdata2, m_rdata2, d_rdata2;
  logic        if_ready2, d_ready2, stall2, m_en2, m_we2;
  logic [1:0]  m_size2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          len;
  } acc_t;

  exp_t dq[$];
  exp_t iq[$];
  acc_t log_q[$];

  // Memory model: one special word, otherwise address-derived data.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], 16'hC0DE};
  endfunction

  assign m_rdata  = mem_model(m_addr);
  assign m_rdata2 = mem_model(m_addr2);

  mem_arbiter #(.MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_size(m_size), .m_rdata(m_rdata)
  );

  mem_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_ready(if_ready2),
    .d_read(1'b0), .d_write(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
    .d_size(2'b00), .d_rdata(d_rdata2), .d_ready(d_ready2), .stall(stall2),
    .m_en(m_en2), .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2),
    .m_size(m_size2), .m_rdata(m_rdata2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every ready pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (d_ready) begin
      if (dq.size() == 0) begin
        chk("d_ready_unexpected", 32'd1, 32'd0);
      end else begin
        e = dq.pop_front();
        chk("d_rdata", d_rdata, e.rdata);
        chk("d_ready_cycle", cyc, e.cyc);
      end
    end
    if (if_ready) begin
      if (iq.size() == 0) begin
        chk("if_ready_unexpected", 32'd1, 32'd0);
      end else begin
        e = iq.pop_front();
        chk("if_rdata", if_rdata, e.rdata);
        chk("if_ready_cycle", cyc, e.cyc);
      end
    end
  end

  // Logger: one record per contiguous m_en burst.
  acc_t cur;
  bit   in_acc = 1'b0;
  always @(negedge clk) begin
    if (m_en) begin
      if (!in_acc) begin
        cur.addr  = m_addr;
        cur.we    = m_we;
        cur.wdata = m_wdata;
        cur.size  = m_size;
        cur.len   = 1;
        in_acc    = 1'b1;
      end else begin
        cur.len++;
      end
    end else if (in_acc) begin
      log_q.push_back(cur);
      in_acc = 1'b0;
    end
  end

  task automatic do_data(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic [31:0] exp_rdata, input int off);
    exp_t e;
    bit   got = 1'b0;
    e.rdata = exp_rdata;
    e.cyc   = cyc + off;
    dq.push_back(e);
    d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata; d_size = size;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d_ready) begin got = 1'b1; break; end
    end
    chk("d_handshake_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_rdata,
                          input int off);
    exp_t e;
    bit   got = 1'b0;
    e.rdata = exp_rdata;
    e.cyc   = cyc + off;
    iq.push_back(e);
    if_req = 1'b1; if_addr = addr;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_ready) begin got = 1'b1; break; end
    end
    chk("if_handshake_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic chk_acc(input int idx, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [1:0] size, input int len);
    if (idx >= log_q.size()) begin
      chk("acc_missing", 32'(idx), 32'hFFFF_FFFF);
    end else begin
      chk("acc_addr", log_q[idx].addr, addr);
      chk("acc_we", {31'd0, log_q[idx].we}, {31'd0, we});
      chk("acc_size", {30'd0, log_q[idx].size}, {30'd0, size});
      chk("acc_len", 32'(log_q[idx].len), 32'(len));
      if (we) chk("acc_wdata", log_q[idx].wdata, wdata);
    end
  endtask

  task automatic end_log(input int n);
    chk("acc_count", 32'(log_q.size()), 32'(n));
    log_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    int  en_cnt;
    bit  got;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    d_read = 1'b0; d_write = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_size = 2'b00;
    if_req2 = 1'b0; if_addr2 = 32'd0;
    idle(2);

    // Reset state
    chk("rst_m_en", {31'd0, m_en}, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_size", {30'd0, m_size}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_readys", {30'd0, if_ready, d_ready}, 32'd0);
    chk("rst_stall_idle", {31'd0, stall}, 32'd0);
    if_req = 1'b1; #1;
    chk("rst_stall_req", {31'd0, stall}, 32'd1);
    if_req = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(1);

    // Simultaneous first requests: data (store) first, fetch after turnaround
    fork
      do_data(1'b0, 1'b1, 32'h40, 32'h1234_5678, 2'b00, 32'd0, 3);
      do_fetch(32'h200, 32'h0200_C0DE, 6);
    join
    idle(2);
    chk_acc(0, 32'h40, 1'b1, 32'h1234_5678, 2'b00, 2);
    chk_acc(1, 32'h200, 1'b0, 32'd0, 2'b00, 2);
    end_log(2);

    // Lone load with stall observation
    fork
      do_data(1'b1, 1'b0, 32'h100, 32'd0, 2'b00, 32'hDEAD_BEEF, 3);
      begin
        @(negedge clk);
        chk("stall_busy", {31'd0, stall}, 32'd1);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (d_ready) break;
        end
        chk("stall_at_ready", {31'd0, stall}, 32'd0);
      end
    join
    idle(2);
    chk_acc(0, 32'h100, 1'b0, 32'd0, 2'b00, 2);
    end_log(1);

    // Both pending after a data grant: fetch wins
    fork
      do_data(1'b1, 1'b0, 32'h300, 32'd0, 2'b00, 32'h0300_C0DE, 6);
      do_fetch(32'h204, 32'h0204_C0DE, 3);
    join
    idle(2);
    chk_acc(0, 32'h204, 1'b0, 32'd0, 2'b00, 2);
    chk_acc(1, 32'h300, 1'b0, 32'd0, 2'b00, 2);
    end_log(2);

    // Reset pulse restores last_d=0 and clears read data
    rst = 1'b1; #1;
    chk("rst2_d_rdata", d_rdata, 32'd0);
    chk("rst2_if_rdata", if_rdata, 32'd0);
    idle(1);
    rst = 1'b0;
    idle(1);

    // Round robin with both sides continuously re-raising: D, I, D, I
    fork
      begin
        do_data(1'b1, 1'b0, 32'h500, 32'd0, 2'b00, 32'h0500_C0DE, 3);
        do_data(1'b1, 1'b0, 32'h504, 32'd0, 2'b00, 32'h0504_C0DE, 5);
      end
      begin
        do_fetch(32'h600, 32'h0600_C0DE, 6);
        do_fetch(32'h604, 32'h0604_C0DE, 5);
      end
    join
    idle(2);
    chk_acc(0, 32'h500, 1'b0, 32'd0, 2'b00, 2);
    chk_acc(1, 32'h600, 1'b0, 32'd0, 2'b00, 2);
    chk_acc(2, 32'h504, 1'b0, 32'd0, 2'b00, 2);
    chk_acc(3, 32'h604, 1'b0, 32'd0, 2'b00, 2);
    end_log(4);

    // Read+write together is a store; d_rdata keeps the last load value
    do_data(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 2'b10, 32'h0504_C0DE, 3);
    idle(2);
    chk_acc(0, 32'h80, 1'b1, 32'hCAFE_F00D, 2'b10, 2);
    end_log(1);

    // Reset during the second cycle of a fetch aborts it asynchronously
    if_req = 1'b1; if_addr = 32'h700;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("abort_m_en_before", {31'd0, m_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_m_en", {31'd0, m_en}, 32'd0);
    chk("abort_m_we", {31'd0, m_we}, 32'd0);
    chk("abort_m_addr", m_addr, 32'd0);
    chk("abort_if_rdata", if_rdata, 32'd0);
    if_req = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(3);
    do_fetch(32'h704, 32'h0704_C0DE, 3);
    idle(2);
    chk_acc(0, 32'h700, 1'b0, 32'd0, 2'b00, 1);
    chk_acc(1, 32'h704, 1'b0, 32'd0, 2'b00, 2);
    end_log(2);

    // MEM_LAT=1 instance: one m_en cycle, if_ready two cycles after request
    c = cyc;
    en_cnt = 0;
    got = 1'b0;
    if_req2 = 1'b1; if_addr2 = 32'h900;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_en2) en_cnt++;
      if (if_ready2) begin
        if (!got) begin
          chk("lat1_ready_cycle", cyc, c + 2);
          chk("lat1_if_rdata", if_rdata2, 32'h0900_C0DE);
        end
        got = 1'b1;
        if_req2 = 1'b0;
      end
    end
    chk("lat1_ready_seen", {31'd0, got}, 32'd1);
    chk("lat1_m_en_cycles", 32'(en_cnt), 32'd1);
    idle(1);

    idle(3);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
